// File: rtl/jt1942_rom_arb.sv
// ---------------------------------------------------------------------------
// jt1942_rom_arb
// Four-slot round-robin arbiter in front of a single shared ROM read port
// with a fixed read latency. Each slot keeps a tag (the address it was last
// granted at), a valid flag and a data register. A slot reads as "ok" only
// while it still requests the exact address its data belongs to, so stale
// data is never flagged valid.
//
// Ports
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_downloading  ROM download in progress; arbitration suspended
//   i_req[3:0]     per-slot read request (0 main CPU, 1 sound, 2 char, 3 obj)
//   i_addr0..3     per-slot word address
//   o_sdram_addr   registered address presented to the shared ROM port
//   i_data_read    shared ROM port read data
//   o_dout0..3     per-slot registered read data
//   o_ok[3:0]      per-slot data valid for the current address
//   o_busy         a ROM access is in flight
// ---------------------------------------------------------------------------
module jt1942_rom_arb #(
  parameter int unsigned AW  = 22,
  parameter int unsigned DW  = 16,
  parameter int unsigned LAT = 2    // legal 1..4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_downloading,
  input  logic [3:0]    i_req,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [AW-1:0] i_addr2,
  input  logic [AW-1:0] i_addr3,
  output logic [AW-1:0] o_sdram_addr,
  input  logic [DW-1:0] i_data_read,
  output logic [DW-1:0] o_dout0,
  output logic [DW-1:0] o_dout1,
  output logic [DW-1:0] o_dout2,
  output logic [DW-1:0] o_dout3,
  output logic [3:0]    o_ok,
  output logic          o_busy
);

  typedef enum logic {StIdle, StWait} state_t;

  state_t        r_state, w_state_d;
  logic [AW-1:0] w_addr [4];
  logic [AW-1:0] r_tag  [4];
  logic [DW-1:0] r_dout [4];
  logic [AW-1:0] r_sdram_addr;
  logic [3:0]    r_valid, w_valid_d;
  logic [3:0]    w_match, w_pend;
  logic [2:0]    r_cnt;
  logic [1:0]    r_last, w_gnt_idx;
  logic          w_gnt_vld, w_grant, w_capture, w_hit;

  assign w_addr[0] = i_addr0;
  assign w_addr[1] = i_addr1;
  assign w_addr[2] = i_addr2;
  assign w_addr[3] = i_addr3;

  assign o_dout0      = r_dout[0];
  assign o_dout1      = r_dout[1];
  assign o_dout2      = r_dout[2];
  assign o_dout3      = r_dout[3];
  assign o_sdram_addr = r_sdram_addr;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_match[i] = (w_addr[i] == r_tag[i]);
    end
  end

  assign o_ok   = r_valid & i_req & w_match;
  assign w_pend = i_req & ~o_ok;

  // Round-robin search starting just after the last granted slot; the
  // fourth step wraps back onto last_grant itself.
  always_comb begin
    logic [1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    idx       = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!w_gnt_vld && w_pend[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  // In-flight slot is always last_grant; data is kept only if that slot
  // still asks for the address it was granted at.
  assign w_hit = i_req[r_last] & w_match[r_last];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    if (i_downloading) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_gnt_vld)     w_state_d = StWait;
        StWait:  if (r_cnt == 3'd1) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_busy    = (r_state == StWait);
    w_grant   = (r_state == StIdle) && !i_downloading && w_gnt_vld;
    w_capture = (r_state == StWait) && !i_downloading && (r_cnt == 3'd1);
  end

  // Valid survives only while the slot keeps asking for its tagged address.
  always_comb begin
    w_valid_d = o_ok;
    if (w_grant)            w_valid_d[w_gnt_idx] = 1'b0;
    if (w_capture && w_hit) w_valid_d[r_last]    = 1'b1;
    if (i_downloading)      w_valid_d            = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_sdram_addr <= '0;
      r_cnt        <= '0;
      r_last       <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        r_tag[i]  <= '0;
        r_dout[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_d;
      if (i_downloading) begin
        r_cnt <= '0;
      end else if (w_grant) begin
        r_sdram_addr     <= w_addr[w_gnt_idx];
        r_tag[w_gnt_idx] <= w_addr[w_gnt_idx];
        r_last           <= w_gnt_idx;
        r_cnt            <= 3'(LAT);
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_capture && w_hit) begin
        r_dout[r_last] <= i_data_read;
      end
    end
  end

endmodule

// File: tb/tb_jt1942_rom_arb.sv
// ---------------------------------------------------------------------------
// tb_jt1942_rom_arb
// Bench for jt1942_rom_arb (LAT=2). A transaction-level model (per-slot
// tag/valid/data, cycles left on the in-flight access, last granted slot) is
// compared against every DUT output each cycle. Directed scenarios pin the
// model with literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_jt1942_rom_arb;
  localparam int unsigned AW  = 22;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dl;
  logic [3:0]    req;
  logic [AW-1:0] a_addr [4];
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] data_read;
  logic [DW-1:0] dout [4];
  logic [3:0]    ok;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  logic [AW-1:0] m_tag  [4];
  logic [DW-1:0] m_dout [4];
  bit            m_valid[4];
  logic [AW-1:0] m_sdram;
  int            m_left;
  int            m_last;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    logic [15:0] t;
    if (a == 22'h000123) return 16'hBEEF;
    t = a[15:0] * 16'd7;
    return t ^ 16'hA5C3 ^ {10'd0, a[21:16]};
  endfunction

  assign data_read = rom(sdram_addr);

  jt1942_rom_arb #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_downloading (dl),
    .i_req         (req),
    .i_addr0       (a_addr[0]),
    .i_addr1       (a_addr[1]),
    .i_addr2       (a_addr[2]),
    .i_addr3       (a_addr[3]),
    .o_sdram_addr  (sdram_addr),
    .i_data_read   (data_read),
    .o_dout0       (dout[0]),
    .o_dout1       (dout[1]),
    .o_dout2       (dout[2]),
    .o_dout3       (dout[3]),
    .o_ok          (ok),
    .o_busy        (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sdram = '0;
    m_left  = 0;
    m_last  = 3;
    for (int i = 0; i < 4; i++) begin
      m_tag[i]   = '0;
      m_dout[i]  = '0;
      m_valid[i] = 0;
    end
  endtask

  // One clock edge of the arbiter, described as transactions.
  task automatic model_step();
    bit            keep[4];
    logic [DW-1:0] rd;
    rd = rom(m_sdram);
    for (int i = 0; i < 4; i++)
      keep[i] = m_valid[i] && req[i] && (a_addr[i] == m_tag[i]);
    if (dl) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
      m_left = 0;
    end else begin
      for (int i = 0; i < 4; i++) m_valid[i] = keep[i];
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0 && req[m_last] && a_addr[m_last] == m_tag[m_last]) begin
          m_dout[m_last]  = rd;
          m_valid[m_last] = 1;
        end
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_last + k) % 4;
          if (req[j] && !keep[j]) begin
            m_sdram    = a_addr[j];
            m_tag[j]   = a_addr[j];
            m_valid[j] = 0;
            m_last     = j;
            m_left     = LAT;
            break;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [3:0] e_ok;
    for (int i = 0; i < 4; i++)
      e_ok[i] = m_valid[i] && req[i] && (a_addr[i] == m_tag[i]);
    chk("ok", ok, e_ok);
    chk("busy", busy, m_left > 0);
    chk("sdram_addr", sdram_addr, m_sdram);
    for (int i = 0; i < 4; i++) chk($sformatf("dout%0d", i), dout[i], m_dout[i]);
  endtask

  // Called at a negedge; returns at the next negedge with checks done.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_model();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting mid-cycle (caller sits at a negedge).
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    chk("rst_busy", busy, 0);
    chk("rst_ok", ok, 0);
    chk("rst_sdram_addr", sdram_addr, 0);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    dl    = 1'b0;
    req   = '0;
    for (int i = 0; i < 4; i++) a_addr[i] = '0;
    @(negedge clk);
    do_reset();

    // Single read of slot 0 at 0x123
    req = 4'b0001; a_addr[0] = 22'h000123;
    cycle();
    chk("s32_addr", sdram_addr, 22'h000123);
    chk("s32_busy1", busy, 1);
    cycle();
    chk("s32_busy2", busy, 1);
    chk("s32_ok_early", ok, 0);
    cycle();
    chk("s32_ok", ok, 4'b0001);
    chk("s32_dout0", dout[0], 16'hBEEF);
    chk("s32_busy_end", busy, 0);

    // All four request together: grants at edges 1,4,7,10
    req = 4'b0000;
    do_reset();
    for (int i = 0; i < 4; i++) a_addr[i] = 22'(32'h200 + 32'h10 * i);
    req = 4'b1111;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      if (e == 1)  chk("s33_g0", sdram_addr, 22'h200);
      if (e == 4)  chk("s33_g1", sdram_addr, 22'h210);
      if (e == 7)  chk("s33_g2", sdram_addr, 22'h220);
      if (e == 10) chk("s33_g3", sdram_addr, 22'h230);
      if (e == 11) chk("s33_ok11", ok, 4'b0111);
    end
    chk("s33_ok12", ok, 4'b1111);

    // Slot 2 address moves after being served
    req = 4'b0000;
    do_reset();
    req = 4'b0100; a_addr[2] = 22'h400;
    repeat (3) cycle();
    chk("s34_ok", ok, 4'b0100);
    chk("s34_dout", dout[2], rom(22'h400));
    a_addr[2] = 22'h401;
    #1;
    chk("s34_drop", ok, 0);
    cycle();
    chk("s34_addr", sdram_addr, 22'h401);
    repeat (2) cycle();
    chk("s34_ok2", ok, 4'b0100);
    chk("s34_dout2", dout[2], rom(22'h401));

    // Slot 1 address moves while its read is in flight
    req = 4'b0000;
    do_reset();
    req = 4'b0010; a_addr[1] = 22'h10;
    cycle();
    chk("s35_addr", sdram_addr, 22'h10);
    a_addr[1] = 22'h11;
    repeat (2) cycle();
    chk("s35_discard_ok", ok, 0);
    chk("s35_discard_dout", dout[1], 0);
    cycle();
    chk("s35_regrant", sdram_addr, 22'h11);
    repeat (2) cycle();
    chk("s35_ok", ok, 4'b0010);

    // Download pulse during an access
    req = 4'b0000;
    do_reset();
    for (int i = 0; i < 4; i++) a_addr[i] = 22'(32'h500 + i);
    req = 4'b1111;
    cycle();
    chk("s36_g0", sdram_addr, 22'h500);
    dl = 1'b1;
    cycle();
    chk("s36_busy", busy, 0);
    chk("s36_ok", ok, 0);
    cycle();
    chk("s36_hold", sdram_addr, 22'h500);
    dl = 1'b0;
    cycle();
    chk("s36_next", sdram_addr, 22'h501);

    // Reset during an access
    req = 4'b0000;
    do_reset();
    a_addr[0] = 22'h600; a_addr[1] = 22'h601;
    req = 4'b0011;
    repeat (4) cycle();
    chk("s37_g1", sdram_addr, 22'h601);
    do_reset();
    cycle();
    chk("s37_first", sdram_addr, 22'h600);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) a = a | 22'h3FFF00;
        a_addr[$urandom_range(0, 3)] = a;
      end
      if (dl) dl = ($urandom_range(0, 1) == 1);
      else    dl = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
